al_completion_tracker: RTL and testbench

//   Receiving end of the writeback control-packet path. Per-lane ctrlPkt fields (valid, alID, flags,

---
 rtl/al_completion_tracker.sv | 156 +++++++++++++++
 tb/tb_al_completion_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/al_completion_tracker.sv
// al_completion_tracker: active list for the writeback control-packet path.
// Entries are allocated in order at the tail. Writeback lanes mark them DONE,
// and up to COMMIT_W entries per cycle retire in order from the head. A retiring
// mispredicted entry closes the commit group for that cycle.
module al_completion_tracker #(
    parameter int AL_DEPTH  = 32,
    parameter int AL_ID_W   = 5,
    parameter int NUM_LANES = 4,
    parameter int COMMIT_W  = 2,
    parameter int PC_W      = 32,
    parameter int FLAG_W    = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            recoverFlag_i,
    input  logic                            allocValid_i,
    output logic                            allocReady_o,
    output logic [AL_ID_W-1:0]              allocID_o,
    input  logic [NUM_LANES-1:0]            ctrlValid_i,
    input  logic [NUM_LANES*AL_ID_W-1:0]    ctrlAlID_i,
    input  logic [NUM_LANES*FLAG_W-1:0]     ctrlFlags_i,
    input  logic [NUM_LANES*PC_W-1:0]       ctrlNextPC_i,
    input  logic [NUM_LANES-1:0]            ctrlDir_i,
    output logic [COMMIT_W-1:0]             commitValid_o,
    output logic [COMMIT_W*AL_ID_W-1:0]     commitAlID_o,
    output logic [COMMIT_W*FLAG_W-1:0]      commitFlags_o,
    output logic [COMMIT_W*PC_W-1:0]        commitNextPC_o,
    output logic                            commitMispred_o,
    output logic [AL_ID_W:0]                count_o,
    output logic                            wbErr_o
);

    localparam int CNT_W = AL_ID_W + 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DONE  = 2'd2
    } ent_st_e;

    ent_st_e           st_q    [AL_DEPTH];
    ent_st_e           st_d    [AL_DEPTH];
    logic [FLAG_W-1:0] flags_q [AL_DEPTH];
    logic [FLAG_W-1:0] flags_d [AL_DEPTH];
    logic [PC_W-1:0]   pc_q    [AL_DEPTH];
    logic [PC_W-1:0]   pc_d    [AL_DEPTH];
    logic              dir_q   [AL_DEPTH];
    logic              dir_d   [AL_DEPTH];

    logic [AL_ID_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic               alloc_fire;
    logic [CNT_W-1:0]   ncommit;

    assign allocReady_o = (count_q < CNT_W'(AL_DEPTH));
    assign allocID_o    = tail_q;
    assign count_o      = count_q;
    assign wbErr_o      = err_q;
    assign alloc_fire   = allocValid_i && allocReady_o;

    // Commit group: contiguous DONE entries from head, closed after a mispredict.
    always_comb begin
        logic               open;
        logic [AL_ID_W-1:0] idx;
        open            = 1'b1;
        idx             = '0;
        ncommit         = '0;
        commitValid_o   = '0;
        commitAlID_o    = '0;
        commitFlags_o   = '0;
        commitNextPC_o  = '0;
        commitMispred_o = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_q + AL_ID_W'(k);
            if (open && st_q[idx] == ST_DONE && CNT_W'(k) < count_q) begin
                commitValid_o[k]                    = 1'b1;
                commitAlID_o[k*AL_ID_W +: AL_ID_W]  = idx;
                commitFlags_o[k*FLAG_W +: FLAG_W]   = flags_q[idx];
                commitNextPC_o[k*PC_W +: PC_W]      = pc_q[idx];
                ncommit                             = ncommit + CNT_W'(1);
                if (flags_q[idx][0]) begin
                    commitMispred_o = 1'b1;
                    open            = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

    // Next state: free committed slots, allocate at tail, apply completions
    // (higher lane last so it wins), then let recovery override everything.
    always_comb begin
        logic [AL_ID_W-1:0] id;
        id      = '0;
        st_d    = st_q;
        flags_d = flags_q;
        pc_d    = pc_q;
        dir_d   = dir_q;
        err_d   = err_q;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (commitValid_o[k]) st_d[head_q + AL_ID_W'(k)] = ST_FREE;
        end
        if (alloc_fire) st_d[tail_q] = ST_ALLOC;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (ctrlValid_i[i]) begin
                id = ctrlAlID_i[i*AL_ID_W +: AL_ID_W];
                if (st_q[id] == ST_ALLOC) begin
                    st_d[id]    = ST_DONE;
                    flags_d[id] = ctrlFlags_i[i*FLAG_W +: FLAG_W];
                    pc_d[id]    = ctrlNextPC_i[i*PC_W +: PC_W];
                    dir_d[id]   = ctrlDir_i[i];
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        head_d  = head_q + ncommit[AL_ID_W-1:0];
        tail_d  = tail_q + AL_ID_W'(alloc_fire);
        count_d = count_q + CNT_W'(alloc_fire) - ncommit;
        if (recoverFlag_i) begin
            for (int e = 0; e < AL_DEPTH; e++) st_d[e] = ST_FREE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            err_d   = err_q;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < AL_DEPTH; e++) st_q[e] <= ST_FREE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Payload storage; only meaningful while the entry is DONE, so no reset.
    always_ff @(posedge clk) begin
        flags_q <= flags_d;
        pc_q    <= pc_d;
        dir_q   <= dir_d;
    end

endmodule

// File: tb/tb_al_completion_tracker.sv
// Directed bench for al_completion_tracker: in-order retire, full list,
// mispredict group cut, lane priority, error flag, recovery and wrap.
module tb_al_completion_tracker;

    localparam int AL_DEPTH = 32, AL_ID_W = 5, NUM_LANES = 4, COMMIT_W = 2, PC_W = 32, FLAG_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic recoverFlag_i = 1'b0;
    logic allocValid_i = 1'b0;
    logic allocReady_o;
    logic [AL_ID_W-1:0] allocID_o;
    logic [NUM_LANES-1:0] ctrlValid_i = '0;
    logic [NUM_LANES*AL_ID_W-1:0] ctrlAlID_i = '0;
    logic [NUM_LANES*FLAG_W-1:0] ctrlFlags_i = '0;
    logic [NUM_LANES*PC_W-1:0] ctrlNextPC_i = '0;
    logic [NUM_LANES-1:0] ctrlDir_i = '0;
    logic [COMMIT_W-1:0] commitValid_o;
    logic [COMMIT_W*AL_ID_W-1:0] commitAlID_o;
    logic [COMMIT_W*FLAG_W-1:0] commitFlags_o;
    logic [COMMIT_W*PC_W-1:0] commitNextPC_o;
    logic commitMispred_o;
    logic [AL_ID_W:0] count_o;
    logic wbErr_o;

    int nchk = 0;
    int nerr = 0;

    al_completion_tracker #(
        .AL_DEPTH(AL_DEPTH), .AL_ID_W(AL_ID_W), .NUM_LANES(NUM_LANES),
        .COMMIT_W(COMMIT_W), .PC_W(PC_W), .FLAG_W(FLAG_W)
    ) dut (
        .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
        .allocValid_i(allocValid_i), .allocReady_o(allocReady_o), .allocID_o(allocID_o),
        .ctrlValid_i(ctrlValid_i), .ctrlAlID_i(ctrlAlID_i), .ctrlFlags_i(ctrlFlags_i),
        .ctrlNextPC_i(ctrlNextPC_i), .ctrlDir_i(ctrlDir_i),
        .commitValid_o(commitValid_o), .commitAlID_o(commitAlID_o),
        .commitFlags_o(commitFlags_o), .commitNextPC_o(commitNextPC_o),
        .commitMispred_o(commitMispred_o), .count_o(count_o), .wbErr_o(wbErr_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int l, input int id, input int fl, input int pc);
        ctrlValid_i[l] = 1'b1;
        ctrlAlID_i[l*AL_ID_W +: AL_ID_W] = AL_ID_W'(id);
        ctrlFlags_i[l*FLAG_W +: FLAG_W] = FLAG_W'(fl);
        ctrlNextPC_i[l*PC_W +: PC_W] = PC_W'(pc);
        ctrlDir_i[l] = 1'b1;
    endtask

    task automatic clr();
        ctrlValid_i = '0; ctrlAlID_i = '0; ctrlFlags_i = '0; ctrlNextPC_i = '0; ctrlDir_i = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(allocReady_o), 64'd1);
        chk("rst_allocid", 64'(allocID_o), 64'd0);
        chk("rst_cvalid", 64'(commitValid_o), 64'd0);
        chk("rst_mispred", 64'(commitMispred_o), 64'd0);
        chk("rst_wberr", 64'(wbErr_o), 64'd0);

        // 1: in-order retire; completions 2,1,0
        allocValid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_allocid", 64'(allocID_o), 64'(i));
            tick();
        end
        allocValid_i = 1'b0;
        chk("t1_count3", 64'(count_o), 64'd3);
        lane(0, 2, 'h10, 'h1002); tick(); clr();
        chk("t1_none_a", 64'(commitValid_o), 64'd0);
        lane(0, 1, 'h10, 'h1001); tick(); clr();
        chk("t1_none_b", 64'(commitValid_o), 64'd0);
        lane(0, 0, 'h10, 'h1000); tick(); clr();
        chk("t1_cv01", 64'(commitValid_o), 64'b11);
        chk("t1_id01", 64'(commitAlID_o), 64'd32);
        chk("t1_pc01", 64'(commitNextPC_o), 64'h00001001_00001000);
        tick();
        chk("t1_cv2", 64'(commitValid_o), 64'b01);
        chk("t1_id2", 64'(commitAlID_o), 64'd2);
        chk("t1_fl2", 64'(commitFlags_o), 64'h10);
        chk("t1_count1", 64'(count_o), 64'd1);
        tick();
        chk("t1_count0", 64'(count_o), 64'd0);

        // 2: fill to 32 (head=tail=3), overflow ignored
        allocValid_i = 1'b1;
        repeat (32) tick();
        chk("t2_count32", 64'(count_o), 64'd32);
        chk("t2_ready0", 64'(allocReady_o), 64'd0);
        tick();
        chk("t2_ovf_count", 64'(count_o), 64'd32);
        chk("t2_ovf_id", 64'(allocID_o), 64'd3);
        lane(0, 3, 0, 'h300); lane(1, 4, 0, 'h400); tick(); clr();
        chk("t2_cv", 64'(commitValid_o), 64'b11);
        chk("t2_ids", 64'(commitAlID_o), 64'd131);
        tick();
        chk("t2_count30", 64'(count_o), 64'd30);
        chk("t2_ready1", 64'(allocReady_o), 64'd1);
        tick();
        allocValid_i = 1'b0;
        chk("t2_count31", 64'(count_o), 64'd31);
        chk("t2_allocid", 64'(allocID_o), 64'd4);

        // 3: mispredict at head=5 ends the group
        lane(0, 5, 'h01, 'h500); lane(1, 6, 'h00, 'h600); tick(); clr();
        chk("t3_cv", 64'(commitValid_o), 64'b01);
        chk("t3_mis", 64'(commitMispred_o), 64'd1);
        chk("t3_id", 64'(commitAlID_o), 64'd5);
        chk("t3_pc", 64'(commitNextPC_o), 64'h500);
        tick();
        chk("t3_cv6", 64'(commitValid_o), 64'b01);
        chk("t3_id6", 64'(commitAlID_o), 64'd6);
        chk("t3_mis6", 64'(commitMispred_o), 64'd0);
        tick();
        chk("t3_count29", 64'(count_o), 64'd29);

        // Recovery with same-cycle alloc and completion
        recoverFlag_i = 1'b1; allocValid_i = 1'b1; lane(0, 7, 0, 'h700);
        tick();
        recoverFlag_i = 1'b0; allocValid_i = 1'b0; clr();
        chk("rec_count", 64'(count_o), 64'd0);
        chk("rec_allocid", 64'(allocID_o), 64'd0);
        chk("rec_cv", 64'(commitValid_o), 64'd0);

        // 4: same-alID completion on lanes 1 and 3, lane 3 wins
        allocValid_i = 1'b1; repeat (5) tick(); allocValid_i = 1'b0;
        for (int l = 0; l < 4; l++) lane(l, l, 0, 'h10 + l);
        tick(); clr();
        chk("t4_cv_a", 64'(commitValid_o), 64'b11);
        chk("t4_id_a", 64'(commitAlID_o), 64'd32);
        tick();
        chk("t4_id_b", 64'(commitAlID_o), 64'd98);
        tick();
        chk("t4_count1", 64'(count_o), 64'd1);
        lane(1, 4, 'h10, 'h100); lane(3, 4, 'h12, 'h200); tick(); clr();
        chk("t4_cv", 64'(commitValid_o), 64'b01);
        chk("t4_id", 64'(commitAlID_o), 64'd4);
        chk("t4_pc", 64'(commitNextPC_o), 64'h200);
        chk("t4_fl", 64'(commitFlags_o), 64'h12);
        chk("t4_noerr", 64'(wbErr_o), 64'd0);
        tick();

        // 5: completion to FREE id 9 sets sticky error; recovery keeps it
        lane(2, 9, 0, 0); tick(); clr();
        chk("t5_err", 64'(wbErr_o), 64'd1);
        chk("t5_cv", 64'(commitValid_o), 64'd0);
        tick();
        chk("t5_err_sticky", 64'(wbErr_o), 64'd1);
        allocValid_i = 1'b1; repeat (10) tick();
        chk("t5_count10", 64'(count_o), 64'd10);
        chk("t5_allocid", 64'(allocID_o), 64'd15);
        recoverFlag_i = 1'b1; tick(); recoverFlag_i = 1'b0; allocValid_i = 1'b0;
        chk("t5_rec_count", 64'(count_o), 64'd0);
        chk("t5_rec_id", 64'(allocID_o), 64'd0);
        chk("t5_rec_err", 64'(wbErr_o), 64'd1);

        // 6: move head/tail to 30, then wrap
        allocValid_i = 1'b1; repeat (30) tick(); allocValid_i = 1'b0;
        chk("t6_count30", 64'(count_o), 64'd30);
        for (int j = 0; j < 8; j++) begin
            for (int l = 0; l < 4; l++) if (4*j + l < 30) lane(l, 4*j + l, 0, 0);
            tick(); clr();
        end
        for (int c = 0; c < 64 && count_o != 0; c++) tick();
        chk("t6_drain", 64'(count_o), 64'd0);
        chk("t6_tail30", 64'(allocID_o), 64'd30);
        allocValid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_wrapid", 64'(allocID_o), 64'((30 + i) % 32));
            tick();
        end
        allocValid_i = 1'b0;
        lane(0, 30, 0, 'h30); lane(1, 31, 0, 'h31); lane(2, 0, 0, 'h0); lane(3, 1, 0, 'h1);
        tick(); clr();
        chk("t6_cv_a", 64'(commitValid_o), 64'b11);
        chk("t6_id_a", 64'(commitAlID_o), 64'd1022);
        chk("t6_tail2", 64'(allocID_o), 64'd2);
        allocValid_i = 1'b1; tick(); allocValid_i = 1'b0;
        chk("t6_count3", 64'(count_o), 64'd3);
        chk("t6_cv_b", 64'(commitValid_o), 64'b11);
        chk("t6_id_b", 64'(commitAlID_o), 64'd32);
        chk("t6_tail3", 64'(allocID_o), 64'd3);
        tick();
        chk("t6_count1", 64'(count_o), 64'd1);
        chk("t6_cv_c", 64'(commitValid_o), 64'd0);

        // Reset clears the sticky error
        reset = 1'b1; tick(); reset = 1'b0;
        chk("end_err", 64'(wbErr_o), 64'd0);
        chk("end_count", 64'(count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
